tmds_channel_decoder: RTL and testbench

//  Receive-side counterpart of the HDMI/TMDS encode path: decodes one TMDS channel of 10-bit

---
 rtl/tmds_channel_decoder.sv | 195 +++++++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: symbol decode plus word-alignment search/lock FSM.
// Requests single-bit deserializer slips until control-token runs show alignment,
// then holds lock while periodic blanking keeps appearing.
module tmds_channel_decoder #(
  parameter int unsigned SEARCH_WIN = 2048,
  parameter int unsigned LOCK_RUN   = 64,
  parameter int unsigned SLIP_WAIT  = 16,
  parameter int unsigned LOSS_WIN   = 4096
) (
  input  logic       pixclk,
  input  logic       rst,
  input  logic [9:0] tmds_sym,
  output logic       bitslip,
  output logic       locked,
  output logic [3:0] slip_cnt,
  output logic       de,
  output logic [7:0] data_out,
  output logic [1:0] c_out
);

  localparam int unsigned SYM_W  = $clog2(SEARCH_WIN) + 1;
  localparam int unsigned RUN_W  = $clog2(LOCK_RUN) + 1;
  localparam int unsigned WAIT_W = $clog2(SLIP_WAIT) + 1;
  localparam int unsigned LOSS_W = $clog2(LOSS_WIN) + 1;

  localparam logic [1:0] ST_SEARCH    = 2'd0;
  localparam logic [1:0] ST_SLIP_WAIT = 2'd1;
  localparam logic [1:0] ST_LOCKED    = 2'd2;

  logic [1:0]        state,    state_n;
  logic [SYM_W-1:0]  sym_cnt,  sym_cnt_n;
  logic [RUN_W-1:0]  ctrl_run, ctrl_run_n;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_n;
  logic [LOSS_W-1:0] loss_cnt, loss_cnt_n;
  logic [3:0]        slip_cnt_n;
  logic              bitslip_n;
  logic              locked_n;
  logic              de_n;
  logic [7:0]        data_out_n;
  logic [1:0]        c_out_n;

  logic              is_token;
  logic [1:0]        token;
  logic [7:0]        d_in;
  logic [7:0]        q_dec;
  logic [RUN_W-1:0]  run_inc;
  logic              run_full;
  logic              hold_lock;

  // Control token detection on the raw symbol
  always_comb begin
    is_token = 1'b1;
    token    = 2'b00;
    case (tmds_sym)
      10'b1101010100: token = 2'b00;
      10'b0010101011: token = 2'b01;
      10'b0101010100: token = 2'b10;
      10'b1010101011: token = 2'b11;
      default:        is_token = 1'b0;
    endcase
  end

  // Data symbol decode: undo the optional inversion, then the XOR/XNOR chain
  always_comb begin
    d_in     = tmds_sym[9] ? ~tmds_sym[7:0] : tmds_sym[7:0];
    q_dec    = 8'h00;
    q_dec[0] = d_in[0];
    for (int i = 1; i < 8; i++) begin
      q_dec[i] = tmds_sym[8] ? (d_in[i] ^ d_in[i-1]) : ~(d_in[i] ^ d_in[i-1]);
    end
  end

  // Saturating run length of consecutive control tokens
  always_comb begin
    if (!is_token) begin
      run_inc = '0;
    end else if (ctrl_run == RUN_W'(LOCK_RUN)) begin
      run_inc = ctrl_run;
    end else begin
      run_inc = ctrl_run + RUN_W'(1);
    end
    run_full = (run_inc == RUN_W'(LOCK_RUN));
  end

  // Next-state, counter and output logic; lock beats window expiry in SEARCH
  always_comb begin
    state_n    = state;
    sym_cnt_n  = sym_cnt;
    ctrl_run_n = run_inc;
    wait_cnt_n = wait_cnt;
    loss_cnt_n = loss_cnt;
    slip_cnt_n = slip_cnt;
    bitslip_n  = 1'b0;
    hold_lock  = 1'b0;
    de_n       = 1'b0;
    data_out_n = 8'h00;
    c_out_n    = 2'b00;

    case (state)
      ST_SEARCH: begin
        if (run_full) begin
          state_n    = ST_LOCKED;
          sym_cnt_n  = '0;
          loss_cnt_n = '0;
        end else if (sym_cnt == SYM_W'(SEARCH_WIN - 1)) begin
          state_n    = ST_SLIP_WAIT;
          bitslip_n  = 1'b1;
          slip_cnt_n = (slip_cnt == 4'd9) ? 4'd0 : slip_cnt + 4'd1;
          sym_cnt_n  = '0;
          wait_cnt_n = '0;
          ctrl_run_n = '0;
        end else begin
          sym_cnt_n = sym_cnt + SYM_W'(1);
        end
      end

      ST_SLIP_WAIT: begin
        ctrl_run_n = '0;
        sym_cnt_n  = '0;
        if (wait_cnt == WAIT_W'(SLIP_WAIT - 1)) begin
          state_n    = ST_SEARCH;
          wait_cnt_n = '0;
        end else begin
          wait_cnt_n = wait_cnt + WAIT_W'(1);
        end
      end

      ST_LOCKED: begin
        if (run_full) begin
          loss_cnt_n = '0;
          hold_lock  = 1'b1;
        end else if (loss_cnt == LOSS_W'(LOSS_WIN - 1)) begin
          state_n    = ST_SEARCH;
          ctrl_run_n = '0;
          sym_cnt_n  = '0;
          loss_cnt_n = '0;
        end else begin
          loss_cnt_n = loss_cnt + LOSS_W'(1);
          hold_lock  = 1'b1;
        end
      end

      default: begin
        state_n    = ST_SEARCH;
        ctrl_run_n = '0;
        sym_cnt_n  = '0;
        wait_cnt_n = '0;
        loss_cnt_n = '0;
      end
    endcase

    // Pixel outputs only while the channel stays locked through this symbol
    if (hold_lock) begin
      if (is_token) begin
        c_out_n = token;
      end else begin
        de_n       = 1'b1;
        data_out_n = q_dec;
        c_out_n    = c_out;
      end
    end

    locked_n = (state_n == ST_LOCKED);
  end

  // State, counter and output registers with synchronous reset
  always_ff @(posedge pixclk) begin
    if (rst) begin
      state    <= ST_SEARCH;
      sym_cnt  <= '0;
      ctrl_run <= '0;
      wait_cnt <= '0;
      loss_cnt <= '0;
      slip_cnt <= 4'd0;
      bitslip  <= 1'b0;
      locked   <= 1'b0;
      de       <= 1'b0;
      data_out <= 8'h00;
      c_out    <= 2'b00;
    end else begin
      state    <= state_n;
      sym_cnt  <= sym_cnt_n;
      ctrl_run <= ctrl_run_n;
      wait_cnt <= wait_cnt_n;
      loss_cnt <= loss_cnt_n;
      slip_cnt <= slip_cnt_n;
      bitslip  <= bitslip_n;
      locked   <= locked_n;
      de       <= de_n;
      data_out <= data_out_n;
      c_out    <= c_out_n;
    end
  end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Scoreboard bench for tmds_channel_decoder: directed symbols with hand-computed
// expectations, plus a bit-rotating deserializer model for the alignment search.
module tb_tmds_channel_decoder;

  localparam int unsigned SEARCH_WIN  = 2048;
  localparam int unsigned SLIP_WAIT   = 16;
  localparam int unsigned SLIP_PERIOD = SEARCH_WIN + SLIP_WAIT;

  localparam logic [9:0] T_C0 = 10'h354;
  localparam logic [9:0] T_C1 = 10'h0AB;
  localparam logic [9:0] T_C2 = 10'h154;
  localparam logic [9:0] T_C3 = 10'h2AB;

  logic       pixclk = 1'b0;
  logic       rst;
  logic [9:0] tmds_sym;
  logic       bitslip;
  logic       locked;
  logic [3:0] slip_cnt;
  logic       de;
  logic [7:0] data_out;
  logic [1:0] c_out;

  tmds_channel_decoder dut (
    .pixclk   (pixclk),
    .rst      (rst),
    .tmds_sym (tmds_sym),
    .bitslip  (bitslip),
    .locked   (locked),
    .slip_cnt (slip_cnt),
    .de       (de),
    .data_out (data_out),
    .c_out    (c_out)
  );

  always #5 pixclk = ~pixclk;

  int unsigned cyc = 0;
  always @(posedge pixclk) cyc <= cyc + 32'd1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       lk;
    logic       bs;
    logic [3:0] sc;
    logic       de;
    logic [7:0] d;
    logic [1:0] c;
  } obs_t;

  typedef struct {
    int unsigned due;
    obs_t        exp;
  } sb_t;

  sb_t   sb_q[$];
  string name_q[$];

  function automatic obs_t ob(input logic lk, input logic bs, input logic [3:0] sc,
                              input logic dv, input logic [7:0] d, input logic [1:0] c);
    obs_t o;
    o.lk = lk; o.bs = bs; o.sc = sc; o.de = dv; o.d = d; o.c = c;
    return o;
  endfunction

  // Expected outputs for the symbol sampled at the next clock edge
  task automatic expect_next(input string nm, input obs_t e);
    sb_t s;
    s.due = cyc + 32'd1;
    s.exp = e;
    sb_q.push_back(s);
    name_q.push_back(nm);
  endtask

  task automatic drive(input logic [9:0] s);
    tmds_sym = s;
    @(posedge pixclk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    expect_next("reset_c1", ob(1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 2'b00));
    drive(10'($urandom));
    expect_next("reset_c2", ob(1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 2'b00));
    drive(10'($urandom));
    rst = 1'b0;
  endtask

  // Monitor: pop due expectations and compare against the DUT away from the active edge
  always @(negedge pixclk) begin
    sb_t   e;
    string nm;
    obs_t  act;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e  = sb_q.pop_front();
      nm = name_q.pop_front();
      act.lk = locked; act.bs = bitslip; act.sc = slip_cnt;
      act.de = de; act.d = data_out; act.c = c_out;
      checks++;
      if (e.due != cyc || act !== e.exp) begin
        errors++;
        $display("FAIL %s cyc=%0d actual lk=%b bs=%b sc=%0d de=%b d=%h c=%b required lk=%b bs=%b sc=%0d de=%b d=%h c=%b",
                 nm, cyc, act.lk, act.bs, act.sc, act.de, act.d, act.c,
                 e.exp.lk, e.exp.bs, e.exp.sc, e.exp.de, e.exp.d, e.exp.c);
      end
    end
  end

  // Transmit stream: 160-token blanking followed by 200 data symbols
  function automatic logic [9:0] tx_sym(input int unsigned n);
    int unsigned p;
    p = n % 360;
    if (p < 160) return T_C0;
    case (p % 4)
      0:       return 10'h100;
      1:       return 10'h0F0;
      2:       return 10'h1FF;
      default: return 10'h2FF;
    endcase
  endfunction

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned base;
    int unsigned exp_slip;
    int unsigned lock_cyc;
    int unsigned n;
    int          off;
    int          nslips;
    int          slip_timing_err;
    int          dbl;
    int          slips_after_lock;
    int          lost;
    logic        prev_bs;
    logic [9:0]  prev_s;
    logic [9:0]  cur_s;
    logic [19:0] comb;

    // Reset state
    reset_dut();

    // Aligned blanking then data decode
    for (int i = 1; i <= 64; i++) begin
      if (i == 63) expect_next("t2_pre_lock", ob(1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 2'b00));
      if (i == 64) expect_next("t2_lock",     ob(1'b1, 1'b0, 4'd0, 1'b0, 8'h00, 2'b00));
      drive(T_C0);
    end
    expect_next("t2_data_100", ob(1'b1, 1'b0, 4'd0, 1'b1, 8'h00, 2'b00)); drive(10'h100);
    // 0x2FF: inverted to 0x00, XNOR chain gives 0xFE
    expect_next("t2_data_2ff", ob(1'b1, 1'b0, 4'd0, 1'b1, 8'hFE, 2'b00)); drive(10'h2FF);
    expect_next("t2_data_1ff", ob(1'b1, 1'b0, 4'd0, 1'b1, 8'h01, 2'b00)); drive(10'h1FF);
    expect_next("t2_data_155", ob(1'b1, 1'b0, 4'd0, 1'b1, 8'hFF, 2'b00)); drive(10'h155);
    expect_next("t2_data_0aa", ob(1'b1, 1'b0, 4'd0, 1'b1, 8'h00, 2'b00)); drive(10'h0AA);
    expect_next("t2_data_300", ob(1'b1, 1'b0, 4'd0, 1'b1, 8'h01, 2'b00)); drive(10'h300);
    expect_next("t2_data_0f0", ob(1'b1, 1'b0, 4'd0, 1'b1, 8'hEE, 2'b00)); drive(10'h0F0);

    // Control tokens while locked
    expect_next("t4_tok_01",  ob(1'b1, 1'b0, 4'd0, 1'b0, 8'h00, 2'b01)); drive(T_C1);
    expect_next("t4_tok_10",  ob(1'b1, 1'b0, 4'd0, 1'b0, 8'h00, 2'b10)); drive(T_C2);
    expect_next("t4_tok_11",  ob(1'b1, 1'b0, 4'd0, 1'b0, 8'h00, 2'b11)); drive(T_C3);
    expect_next("t4_c_hold",  ob(1'b1, 1'b0, 4'd0, 1'b1, 8'h00, 2'b11)); drive(10'h100);

    // Loss of lock: refresh with a full token run, then data only
    for (int i = 1; i <= 64; i++) begin
      if (i == 64) expect_next("t5_refresh", ob(1'b1, 1'b0, 4'd0, 1'b0, 8'h00, 2'b00));
      drive(T_C0);
    end
    for (int k = 1; k <= 4096; k++) begin
      if (k == 4095) expect_next("t5_last_locked", ob(1'b1, 1'b0, 4'd0, 1'b1, 8'h00, 2'b00));
      if (k == 4096) expect_next("t5_unlock",      ob(1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 2'b00));
      drive(10'h100);
    end
    // SEARCH resumes from sym_cnt 0: slip 2048 symbols after the unlock edge
    for (int k = 1; k <= 2048; k++) begin
      if (k == 1)    expect_next("t5_after",    ob(1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 2'b00));
      if (k == 2047) expect_next("t5_pre_slip", ob(1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 2'b00));
      if (k == 2048) expect_next("t5_slip",     ob(1'b0, 1'b1, 4'd1, 1'b0, 8'h00, 2'b00));
      drive(10'h100);
    end

    // Reset on the fifth SLIP_WAIT cycle
    expect_next("t6_no_double_slip", ob(1'b0, 1'b0, 4'd1, 1'b0, 8'h00, 2'b00));
    drive(T_C0);
    drive(T_C0);
    drive(T_C0);
    drive(T_C0);
    rst = 1'b1;
    expect_next("t6_reset_in_wait", ob(1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 2'b00));
    drive(10'h100);
    rst = 1'b0;
    for (int k = 1; k <= 2048; k++) begin
      if (k == 1)    expect_next("t6_search_start", ob(1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 2'b00));
      if (k == 2047) expect_next("t6_search_pre",   ob(1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 2'b00));
      if (k == 2048) expect_next("t6_search_slip",  ob(1'b0, 1'b1, 4'd1, 1'b0, 8'h00, 2'b00));
      drive(10'h100);
    end

    // Misaligned deserializer: starts 3 bits off, rotates one bit per bitslip
    reset_dut();
    base             = cyc;
    exp_slip         = base + SEARCH_WIN;
    lock_cyc         = 0;
    n                = 0;
    off              = 3;
    nslips           = 0;
    slip_timing_err  = 0;
    dbl              = 0;
    slips_after_lock = 0;
    lost             = 0;
    prev_bs          = 1'b0;
    prev_s           = T_C0;
    cur_s            = T_C0;
    for (int k = 0; k < 8 * SLIP_PERIOD + 6000; k++) begin
      prev_s = cur_s;
      cur_s  = tx_sym(n);
      n++;
      comb = {cur_s, prev_s};
      drive(comb[off +: 10]);
      if (bitslip) begin
        if (lock_cyc != 0) begin
          slips_after_lock++;
        end else begin
          nslips++;
          if (cyc != exp_slip) slip_timing_err++;
          exp_slip = cyc + SLIP_PERIOD;
        end
        if (prev_bs) dbl++;
        off = (off == 9) ? 0 : off + 1;
      end
      prev_bs = bitslip;
      if (lock_cyc == 0 && locked) lock_cyc = cyc;
      if (lock_cyc != 0 && !locked) lost++;
      if (lock_cyc != 0 && cyc >= lock_cyc + 3000) break;
    end
    chk("t3_lock_seen",        int'(lock_cyc != 0), 1);
    chk("t3_slips_before_lock", nslips, 7);
    chk("t3_slip_spacing",     slip_timing_err, 0);
    chk("t3_slip_cnt",         int'(slip_cnt), 7);
    chk("t3_slips_after_lock", slips_after_lock, 0);
    chk("t3_back_to_back",     dbl, 0);
    chk("t3_lock_dropped",     lost, 0);
    chk("t3_locked_end",       int'(locked), 1);

    @(negedge pixclk);
    #1;
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
